window_3x3_line_buffer: RTL and testbench

- Upstream neighbour of the decision-tree denoiser core (mTopModule).
- Accepts a raster-order grey pixel stream, one pixel per handshake.
- Holds two image lines in line buffers and emits, per pixel, the 3x3 neighbourhood (a,b,c,d,fij,e,f,g,h) with zero padding at image borders.
- Replaces the behavioural window construction currently done in the bench, so the denoiser can sit in a streaming path.

---
 rtl/window_pkg.sv | 30 +++
 rtl/window_3x3_line_buffer_if.sv | 30 +++
 rtl/line_buffer_ram.sv | 23 ++
 rtl/window_3x3_line_buffer.sv | 164 ++++++++++++++++
 tb/tb_window_3x3_line_buffer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared types and constants for the 3x3 window line buffer (WIN_REPLICATE_PAD_EN selects edge replication)
package window_pkg;

    localparam int PIXEL_W       = 8;
    localparam int WIN_SIZE      = 9;
    localparam int NUM_LINE_BUFS = 2;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t a;
        pixel_t b;
        pixel_t c;
        pixel_t d;
        pixel_t fij;
        pixel_t e;
        pixel_t f;
        pixel_t g;
        pixel_t h;
    } window_t;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

`ifdef WIN_REPLICATE_PAD_EN
    localparam bit REPLICATE_PAD = 1'b1;
`else
    localparam bit REPLICATE_PAD = 1'b0;
`endif

endpackage

// File: rtl/window_3x3_line_buffer_if.sv
// rtl/window_3x3_line_buffer_if.sv - pixel stream in, 3x3 window out, frame-done pulse
interface window_3x3_line_buffer_if
    import window_pkg::*;
#(
    parameter int pPixelWidth = PIXEL_W
);
    logic                   iDataValid;
    logic [pPixelWidth-1:0] iv8Pixel;
    logic                   oReady;
    logic                   oWindowValid;
    logic                   iWindowReady;
    logic [pPixelWidth-1:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c;
    logic [pPixelWidth-1:0] ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e;
    logic [pPixelWidth-1:0] ov8Pixel_f, ov8Pixel_g, ov8Pixel_h;
    logic                   oFrameDone;

    modport master (
        output iDataValid, iv8Pixel, iWindowReady,
        input  oReady, oWindowValid, oFrameDone,
        input  ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
        input  ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h
    );

    modport slave (
        input  iDataValid, iv8Pixel, iWindowReady,
        output oReady, oWindowValid, oFrameDone,
        output ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
        output ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h
    );
endinterface

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one-line circular buffer, combinational read-before-write at a shared address
module line_buffer_ram #(
    parameter int pDepth     = 512,
    parameter int pWidth     = 8,
    parameter int pAddrWidth = $clog2(pDepth)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [pAddrWidth-1:0] addr_i,
    input  logic [pWidth-1:0]     wr_data_i,
    output logic [pWidth-1:0]     rd_data_o
);
    logic [pWidth-1:0] mem_q [pDepth];

    // The read sees the value written one full line earlier, before this cycle's write lands.
    assign rd_data_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/window_3x3_line_buffer.sv
// rtl/window_3x3_line_buffer.sv - streaming 3x3 neighbourhood builder with border padding
// Zero padding by default; define WIN_REPLICATE_PAD_EN for edge replication.
module window_3x3_line_buffer
    import window_pkg::*;
#(
    parameter int pImageWidth = 512,
    parameter int pImageHight = 512,
    parameter int pPixelWidth = PIXEL_W
) (
    input  logic                    iClk,
    input  logic                    iRst,
    window_3x3_line_buffer_if.slave win_if
);
    localparam int N  = pImageWidth * pImageHight;
    localparam int CW = $clog2(pImageWidth);
    localparam int RW = $clog2(pImageHight);
    localparam int NW = $clog2(N + 1);

    typedef logic [pPixelWidth-1:0] pix_t;

    state_t        state_q;
    logic [NW-1:0] in_cnt_q, win_cnt_q;
    logic [RW-1:0] cen_r_q;
    logic [CW-1:0] cen_c_q, addr_q;
    logic          valid_q, valid_d, done_q;
    pix_t          col1_q [3];
    pix_t          col2_q [3];
    pix_t          win_q [WIN_SIZE];
    pix_t          win_d [WIN_SIZE];
    pix_t          lb_in  [NUM_LINE_BUFS];
    pix_t          lb_out [NUM_LINE_BUFS];
    pix_t          raw  [3][3];
    pix_t          rowp [3][3];
    pix_t          colp [3][3];
    pix_t          pix_in;
    logic          ready, accept, flush_step, advance, load, consume;
    logic          top_edge, bot_edge, left_edge, right_edge;

    assign ready      = !iRst && (state_q != FLUSH) && (!valid_q || win_if.iWindowReady);
    assign accept     = win_if.iDataValid && ready;
    // Flush steps push a dummy pixel; it only ever lands in padded positions.
    assign flush_step = !iRst && (state_q == FLUSH) && (!valid_q || win_if.iWindowReady)
                        && (win_cnt_q != NW'(N));
    assign advance    = accept || flush_step;
    assign load       = flush_step || (accept && state_q == RUN);
    assign consume    = valid_q && win_if.iWindowReady;
    assign valid_d    = load || (valid_q && !win_if.iWindowReady);
    assign pix_in     = flush_step ? '0 : win_if.iv8Pixel;

    assign lb_in[0] = pix_in;
    for (genvar i = 1; i < NUM_LINE_BUFS; i++) begin : g_chain
        assign lb_in[i] = lb_out[i-1];
    end

    for (genvar i = 0; i < NUM_LINE_BUFS; i++) begin : g_lb
        line_buffer_ram #(
            .pDepth    (pImageWidth),
            .pWidth    (pPixelWidth),
            .pAddrWidth(CW)
        ) u_lb (
            .clk_i    (iClk),
            .wr_en_i  (advance),
            .addr_i   (addr_q),
            .wr_data_i(lb_in[i]),
            .rd_data_o(lb_out[i])
        );
    end

    assign top_edge   = (cen_r_q == '0);
    assign bot_edge   = (cen_r_q == RW'(pImageHight - 1));
    assign left_edge  = (cen_c_q == '0);
    assign right_edge = (cen_c_q == CW'(pImageWidth - 1));

    // Columns are [left, centre, right], rows within a column are [top, mid, bottom].
    always_comb begin
        raw[0]    = col2_q;
        raw[1]    = col1_q;
        raw[2][0] = lb_out[1];
        raw[2][1] = lb_out[0];
        raw[2][2] = pix_in;
        rowp      = raw;
        for (int k = 0; k < 3; k++) begin
            if (top_edge) rowp[k][0] = REPLICATE_PAD ? raw[k][1] : '0;
            if (bot_edge) rowp[k][2] = REPLICATE_PAD ? raw[k][1] : '0;
        end
        colp = rowp;
        for (int j = 0; j < 3; j++) begin
            if (left_edge)  colp[0][j] = REPLICATE_PAD ? rowp[1][j] : '0;
            if (right_edge) colp[2][j] = REPLICATE_PAD ? rowp[1][j] : '0;
        end
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                win_d[3*j + k] = colp[k][j];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            win_cnt_q <= '0;
            cen_r_q   <= '0;
            cen_c_q   <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            col1_q    <= '{default: '0};
            col2_q    <= '{default: '0};
            win_q     <= '{default: '0};
        end else begin
            done_q  <= 1'b0;
            valid_q <= valid_d;
            if (advance) begin
                addr_q <= (addr_q == CW'(pImageWidth - 1)) ? '0 : addr_q + CW'(1);
                col2_q <= col1_q;
                col1_q <= '{lb_out[1], lb_out[0], pix_in};
            end
            if (load) begin
                win_q     <= win_d;
                win_cnt_q <= win_cnt_q + NW'(1);
                if (right_edge) begin
                    cen_c_q <= '0;
                    cen_r_q <= cen_r_q + RW'(1);
                end else begin
                    cen_c_q <= cen_c_q + CW'(1);
                end
            end
            case (state_q)
                FILL: if (accept) begin
                    in_cnt_q <= in_cnt_q + NW'(1);
                    if (in_cnt_q == NW'(pImageWidth)) state_q <= RUN;
                end
                RUN: if (accept) begin
                    in_cnt_q <= in_cnt_q + NW'(1);
                    if (in_cnt_q == NW'(N - 1)) state_q <= FLUSH;
                end
                FLUSH: if (consume && win_cnt_q == NW'(N)) begin
                    state_q   <= FILL;
                    in_cnt_q  <= '0;
                    win_cnt_q <= '0;
                    cen_r_q   <= '0;
                    cen_c_q   <= '0;
                    addr_q    <= '0;
                    done_q    <= 1'b1;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign win_if.oReady       = ready;
    assign win_if.oWindowValid = valid_q;
    assign win_if.oFrameDone   = done_q;
    assign win_if.ov8Pixel_a   = win_q[0];
    assign win_if.ov8Pixel_b   = win_q[1];
    assign win_if.ov8Pixel_c   = win_q[2];
    assign win_if.ov8Pixel_d   = win_q[3];
    assign win_if.ov8Pixel_fij = win_q[4];
    assign win_if.ov8Pixel_e   = win_q[5];
    assign win_if.ov8Pixel_f   = win_q[6];
    assign win_if.ov8Pixel_g   = win_q[7];
    assign win_if.ov8Pixel_h   = win_q[8];
endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// tb/tb_window_3x3_line_buffer.sv - self-checking bench for window_3x3_line_buffer on a 4x4 image
module tb_window_3x3_line_buffer;
    import window_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    window_3x3_line_buffer_if #(.pPixelWidth(8)) wif ();

    window_3x3_line_buffer #(
        .pImageWidth(W),
        .pImageHight(H),
        .pPixelWidth(8)
    ) dut (
        .iClk  (clk),
        .iRst  (rst),
        .win_if(wif)
    );

    always #5 clk = ~clk;

    window_t obs_q[$];
    int      done_cnt, acc6_cyc, win1_cyc;
    bit      stall_stable, stall_ready_low;

    function automatic window_t cur_win();
        return {wif.ov8Pixel_a, wif.ov8Pixel_b, wif.ov8Pixel_c, wif.ov8Pixel_d, wif.ov8Pixel_fij,
                wif.ov8Pixel_e, wif.ov8Pixel_f, wif.ov8Pixel_g, wif.ov8Pixel_h};
    endfunction

    // Neighbourhood of raster index n, pixel value = base + index + 1.
    function automatic window_t model_win(input int base, input int n);
        pixel_t p [9];
        int     r, c, rr, cc;
        r = n / W;
        c = n % W;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
`ifdef WIN_REPLICATE_PAD_EN
                rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
                cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
                p[dr*3 + dc] = pixel_t'(base + rr*W + cc + 1);
`else
                p[dr*3 + dc] = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? '0
                               : pixel_t'(base + rr*W + cc + 1);
`endif
            end
        end
        return {p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7], p[8]};
    endfunction

    // vmode: 0 continuous, 1 pattern 1,0,0,1, 2 random; rmode: 0 always ready, 1 stall at window 7, 2 random
    task automatic drive_frame(input int base, input int vmode, input int rmode,
                               input int max_pix, input int max_cyc);
        int      pix_idx, cyc, tail, stall_left, vphase;
        bit      stall_done, v, r;
        window_t held;
        pix_idx = 0; cyc = 0; tail = -1; stall_left = 0; vphase = 0;
        stall_done = 1'b0; held = '0;
        obs_q.delete();
        done_cnt = 0; acc6_cyc = -1; win1_cyc = -1;
        stall_stable = 1'b1; stall_ready_low = 1'b1;
        while (cyc < max_cyc && tail != 0) begin
            if (rmode == 1 && !stall_done && wif.oWindowValid && obs_q.size() == 6) begin
                stall_left = 5;
                stall_done = 1'b1;
                held = cur_win();
            end
            case (rmode)
                0:       r = 1'b1;
                1:       r = (stall_left == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            case (vmode)
                0:       v = 1'b1;
                1:       v = (vphase % 4 == 0) || (vphase % 4 == 3);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            vphase++;
            v = v && (pix_idx < max_pix);
            wif.iWindowReady = r;
            wif.iDataValid   = v;
            wif.iv8Pixel     = v ? 8'(base + pix_idx + 1) : 8'($urandom);
            @(negedge clk);
            if (stall_left > 0) begin
                if (!wif.oWindowValid || cur_win() !== held) stall_stable = 1'b0;
                if (wif.oReady) stall_ready_low = 1'b0;
                stall_left--;
            end
            if (wif.oWindowValid && wif.iWindowReady) begin
                if (win1_cyc < 0) win1_cyc = cyc;
                obs_q.push_back(cur_win());
            end
            if (wif.iDataValid && wif.oReady) begin
                if (pix_idx == W + 1) acc6_cyc = cyc;
                pix_idx++;
            end
            if (wif.oFrameDone) begin
                done_cnt++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            cyc++;
            @(posedge clk);
            #1;
        end
        wif.iDataValid   = 1'b0;
        wif.iWindowReady = 1'b1;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        wif.iDataValid   = 1'b0;
        wif.iWindowReady = 1'b0;
        wif.iv8Pixel     = '0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wif.iDataValid   = 1'b1;
        wif.iWindowReady = 1'b1;
        wif.iv8Pixel     = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (wif.oReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wif.oReady); end
        checks++; if (wif.oWindowValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", wif.oWindowValid); end
        checks++; if (wif.oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", wif.oFrameDone); end
        checks++; if (cur_win() !== window_t'(0)) begin errors++; $display("FAIL reset_window got %h exp 0", cur_win()); end
        wif.iDataValid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (wif.oReady !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", wif.oReady); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        window_t got, exp_first, exp_mid, exp_last;
`ifdef WIN_REPLICATE_PAD_EN
        exp_first = {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6};
        exp_last  = {8'd11, 8'd12, 8'd12, 8'd15, 8'd16, 8'd16, 8'd15, 8'd16, 8'd16};
`else
        exp_first = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
        exp_last  = {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
        exp_mid = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
        drive_frame(0, 0, 0, N, 200);
        checks++; if (obs_q.size() != N) begin errors++; $display("FAIL stream_count got %0d exp %0d", obs_q.size(), N); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stream_done got %0d exp 1", done_cnt); end
        checks++; if (acc6_cyc < 0 || win1_cyc - acc6_cyc != 1) begin errors++; $display("FAIL stream_latency got %0d exp 1", win1_cyc - acc6_cyc); end
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        checks++; if (got !== exp_first) begin errors++; $display("FAIL stream_first got %h exp %h", got, exp_first); end
        got = (obs_q.size() > 5) ? obs_q[5] : 'x;
        checks++; if (got !== exp_mid) begin errors++; $display("FAIL stream_centre6 got %h exp %h", got, exp_mid); end
        got = (obs_q.size() > 15) ? obs_q[15] : 'x;
        checks++; if (got !== exp_last) begin errors++; $display("FAIL stream_last got %h exp %h", got, exp_last); end
        for (int i = 0; i < N; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== model_win(0, i)) begin errors++; $display("FAIL stream_win%0d got %h exp %h", i, got, model_win(0, i)); end
        end
    endtask

    task automatic test_backpressure();
        window_t got;
        drive_frame(0, 0, 1, N, 200);
        checks++; if (!stall_stable) begin errors++; $display("FAIL bp_hold got unstable exp stable"); end
        checks++; if (!stall_ready_low) begin errors++; $display("FAIL bp_ready got 1 exp 0"); end
        checks++; if (obs_q.size() != N) begin errors++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), N); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
        for (int i = 0; i < N; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== model_win(0, i)) begin errors++; $display("FAIL bp_win%0d got %h exp %h", i, got, model_win(0, i)); end
        end
    endtask

    task automatic test_bubbles();
        window_t got;
        drive_frame(0, 1, 0, N, 300);
        checks++; if (obs_q.size() != N) begin errors++; $display("FAIL bub_count got %0d exp %0d", obs_q.size(), N); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bub_done got %0d exp 1", done_cnt); end
        for (int i = 0; i < N; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== model_win(0, i)) begin errors++; $display("FAIL bub_win%0d got %h exp %h", i, got, model_win(0, i)); end
        end
    endtask

    task automatic test_reset_midframe();
        window_t got, exp_first;
`ifdef WIN_REPLICATE_PAD_EN
        exp_first = {8'd101, 8'd101, 8'd102, 8'd101, 8'd101, 8'd102, 8'd105, 8'd105, 8'd106};
`else
        exp_first = {8'd0, 8'd0, 8'd0, 8'd0, 8'd101, 8'd102, 8'd0, 8'd105, 8'd106};
`endif
        drive_frame(0, 0, 0, 9, 9);
        apply_reset(1);
        checks++; if (wif.oWindowValid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", wif.oWindowValid); end
        drive_frame(100, 0, 0, N, 200);
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        checks++; if (got !== exp_first) begin errors++; $display("FAIL mid_first got %h exp %h", got, exp_first); end
        checks++; if (obs_q.size() != N) begin errors++; $display("FAIL mid_count got %0d exp %0d", obs_q.size(), N); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_done got %0d exp 1", done_cnt); end
        for (int i = 0; i < N; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== model_win(100, i)) begin errors++; $display("FAIL mid_win%0d got %h exp %h", i, got, model_win(100, i)); end
        end
    endtask

    task automatic test_back_to_back();
        window_t got;
        int      base;
        for (int f = 0; f < 3; f++) begin
            base = $urandom_range(0, 230);
            drive_frame(base, 2, 2, N, 600);
            checks++; if (obs_q.size() != N) begin errors++; $display("FAIL b2b%0d_count got %0d exp %0d", f, obs_q.size(), N); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b%0d_done got %0d exp 1", f, done_cnt); end
            for (int i = 0; i < N; i++) begin
                got = (i < obs_q.size()) ? obs_q[i] : 'x;
                checks++;
                if (got !== model_win(base, i)) begin errors++; $display("FAIL b2b%0d_win%0d got %h exp %h", f, i, got, model_win(base, i)); end
            end
        end
    endtask

    initial begin
        wif.iDataValid   = 1'b0;
        wif.iWindowReady = 1'b0;
        wif.iv8Pixel     = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
